// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_restoring_divider_if
// Brief   : Operand/result bundle for the sequential restoring divider.
// Rev     : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_restoring_divider
// Brief   : Multi-cycle unsigned restoring divider, one trial subtract/clock.
// Rev     : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  // One extra bit keeps the borrow visible so all-ones / 1 cannot wrap.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;

  always_comb begin
    partial = {rem_q, dvd_q[WIDTH-1]};
    diff    = partial - {1'b0, dsr_q};
  end

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dsr_d         = dsr_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CNT_W'(WIDTH);
          dz_d  = (bus.divisor == '0);
          state_d = (bus.divisor == '0) ? S_FINISH : S_CALC;
        end
      end

      S_CALC: begin
        busy_d = 1'b1;
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = partial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        // Status flops lag the state by one edge, so results land with done.
        done_d        = 1'b1;
        quotient_d    = dz_q ? '1 : quo_q;
        remainder_d   = dz_q ? dvd_q : rem_q;
        div_by_zero_d = dz_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dvd_q         <= '0;
      dsr_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dsr_q         <= dsr_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_restoring_divider
// Brief   : Scoreboard bench for seq_restoring_divider at WIDTH=4.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got q=%0d r=%0d required no done at %0t",
                 bus.quotient, bus.remainder, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient",    32'(bus.quotient),    32'(mon_e.q));
        check("remainder",   32'(bus.remainder),   32'(mon_e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.dz));
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic edz);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    exp_q.push_back('{eq, er, edz});
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_done_after_accept", 32'({bus.busy, bus.done}), 32'(2'b00));
    if (edz) begin
      @(negedge clk);
      check("dz_busy_done", 32'({bus.busy, bus.done}), 32'(2'b01));
    end else begin
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        check("calc_busy_done", 32'({bus.busy, bus.done}), 32'(2'b10));
      end
      @(negedge clk);
      check("finish_busy_done", 32'({bus.busy, bus.done}), 32'(2'b01));
    end
    @(negedge clk);
    check("idle_after_done", 32'({bus.busy, bus.done}), 32'(2'b00));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int       n_done;
    logic     got;
    int       a, b;
    exp_t     e;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2;
    check("reset_outputs", 32'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    issue(4'd3, 4'd7, 4'd0, 4'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_outputs", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'({4'd0, 4'd3, 1'b0}));
    end

    issue(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    @(negedge clk);
    check("dz_hold", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'({4'd15, 4'd9, 1'b1}));
    issue(4'd8, 4'd3, 4'd2, 4'd2, 1'b0);

    // Second start mid-CALC plus operand churn must not disturb 14/5.
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    exp_q.push_back('{4'd2, 4'd4, 1'b0});
    n_done = 0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.dividend = 4'd6;
    bus.divisor  = 4'd2;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 4'd15;
    bus.divisor  = 4'd1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("single_done", 32'(n_done), 32'(1));

    // Asynchronous reset in the middle of a CALC.
    @(negedge clk);
    bus.dividend = 4'd12;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    check("no_activity_after_reset", 32'(n_done), 32'(0));
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);

    // Exhaustive sweep with start held high: back-to-back operations.
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i / 16;
      b = i % 16;
      bus.dividend = 4'(a);
      bus.divisor  = 4'(b);
      if (b == 0) e = '{4'hF, 4'(a), 1'b1};
      else        e = '{4'(a / b), 4'(a % b), 1'b0};
      exp_q.push_back(e);
      @(negedge clk);
      check("sweep_idle_gap", 32'({bus.busy, bus.done}), 32'(2'b00));
      got = 1'b0;
      for (int t = 0; t < 30 && !got; t++) begin
        @(negedge clk);
        if (bus.done) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL sweep_timeout: got no done required done for %0d/%0d", a, b);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("sweep_end_idle", 32'({bus.busy, bus.done}), 32'(2'b00));
    repeat (8) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned divider; the subtract-direction counterpart to the team's switch-driven adder datapath.
- Operands come from board switches. A one-cycle start pulse comes from the team's button debouncer. Quotient, remainder and status drive LEDs.
- Restoring algorithm: one trial subtraction per clock, WIDTH iterations, with a start/busy/done handshake.

Parameters:
WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, sampled on accepted start
divisor  input  WIDTH  unsigned divisor, sampled on accepted start
quotient  output  WIDTH  result quotient, registered
remainder  output  WIDTH  result remainder, registered
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  high with results when the latched divisor was 0

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - All working registers cleared.
  - Reset mid-operation aborts the operation with no done pulse. The first clock after rst deasserts is in IDLE.
- States:
  - IDLE: busy=0. On start=1, latch the operands. If the divisor is 0, go to FINISH. Otherwise go to CALC and load the iteration counter with WIDTH.
  - CALC: busy=1. Run exactly WIDTH cycles, then go to FINISH.
  - FINISH: lasts exactly one cycle. done=1, busy=0. Output registers take their new values on entry to this state. Next state is IDLE.
- Iteration (CALC, per cycle):
  - partial = {rem_w[WIDTH-1:0], dvd_w[WIDTH-1]}, WIDTH+1 bits.
  - dvd_w shifts left by 1.
  - diff = partial - {1'b0, dsr_w}, computed at WIDTH+1 bits.
  - If diff[WIDTH]=0: rem_w=diff[WIDTH-1:0] and shift 1 into the quotient working register LSB.
  - Otherwise: rem_w=partial[WIDTH-1:0] and shift 0 into the LSB.
  - The counter decrements; leave CALC when it reaches 0.
- Latency:
  - Start is sampled at edge 0. busy is high after edges 1..WIDTH. done is high for the cycle after edge WIDTH+1.
  - Divide-by-zero: done is high after edge 1 and busy never asserts.
- Divide-by-zero results: quotient = all ones, remainder = latched dividend, div_by_zero=1.
- Output hold:
  - quotient, remainder and div_by_zero hold their values from FINISH until the next FINISH or reset.
  - Outputs never show intermediate values during CALC.
  - div_by_zero clears on the next normal completion.
- Boundary conditions:
  - start during CALC or FINISH: ignored, with no queuing.
  - start held high continuously: a new operation is accepted on each IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
  - Operand inputs changing after the accepted start have no effect on the operation in progress.
  - dividend < divisor: quotient=0, remainder=dividend.
  - Maximum operands (all ones / 1): quotient=all ones, remainder=0. The WIDTH+1-bit trial subtraction must not overflow.

Test Plan:
- WIDTH=4, 13/4, start pulse -> busy for 4 cycles, done pulse on the 5th cycle after start; quotient=3, remainder=1, div_by_zero=0.
- 15/1 -> quotient=15, remainder=0. Then 3/7 -> quotient=0, remainder=3. Outputs hold between operations with start=0.
- 9/0 -> done one cycle after start, busy never 1; quotient=15, remainder=9, div_by_zero=1. Then 8/3 -> quotient=2, remainder=2, div_by_zero=0.
- Start 14/5, pulse start again at cycle 2 with 6/2, and change operands mid-CALC -> single done; quotient=2, remainder=4.
- Start 12/5, assert rst at cycle 2 (asynchronous, mid-cycle) -> all outputs 0 immediately and no done. After release, 12/5 -> quotient=2, remainder=2.
- Exhaustive sweep of all 256 operand pairs (WIDTH=4), checked against a reference model. Include start held high for back-to-back runs, with one IDLE cycle between each done and the next busy.
